soc_cluster_boot_seq: RTL and testbench

//  Boot sequencer for the SoC control block. Takes start/stop pulses and a cluster mask decoded from
//  the APB RW core-control register and sequences per-cluster reset release, staggered by a fixed
//  gap, then fetch-enable. A status word feeds back to an APB RO register for host polling.

---
 rtl/soc_cluster_boot_seq.sv | 160 ++++++++++++++++
 tb/tb_soc_cluster_boot_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/soc_cluster_boot_seq.sv
// Cluster boot sequencer: holds all requested clusters in reset, releases them one by one with a
// fixed stagger, then enables instruction fetch. Status word mirrors the outputs for APB polling.
// Optional feature: define SOC_BOOT_SEQ_AUTOBOOT_EN to leave reset already in HOLD with all
// clusters selected, so the boot runs without a start pulse.
module soc_cluster_boot_seq #(
  parameter int unsigned N_CLUSTERS      = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned STAGGER_CYCLES  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [N_CLUSTERS-1:0] cl_mask_i,
  output logic [N_CLUSTERS-1:0] cluster_rst_no,
  output logic [N_CLUSTERS-1:0] fetch_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] status_o
);

  localparam int unsigned MaxCnt = (RST_HOLD_CYCLES > STAGGER_CYCLES) ? RST_HOLD_CYCLES
                                                                       : STAGGER_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(RST_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StagLast = CntW'(STAGGER_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(MaxCnt);

  typedef enum logic [1:0] {StIdle, StHold, StRelease, StRun} state_e;

`ifdef SOC_BOOT_SEQ_AUTOBOOT_EN
  localparam state_e                 ResetState = StHold;
  localparam logic [N_CLUSTERS-1:0]  ResetMask  = '1;
  localparam logic                   ResetBusy  = 1'b1;
`else
  localparam state_e                 ResetState = StIdle;
  localparam logic [N_CLUSTERS-1:0]  ResetMask  = '0;
  localparam logic                   ResetBusy  = 1'b0;
`endif

  if (2 * N_CLUSTERS + 2 > DATA_WIDTH) begin : gen_width_check
    $error("status_o too narrow for 2*N_CLUSTERS+2 bits");
  end
  if (RST_HOLD_CYCLES < 1 || STAGGER_CYCLES < 1) begin : gen_cycles_check
    $error("RST_HOLD_CYCLES and STAGGER_CYCLES must be >= 1");
  end

  state_e                state_q, state_d;
  logic [N_CLUSTERS-1:0] mask_q, mask_d;
  // Masked clusters not yet released; the lowest set bit is the next one to go.
  logic [N_CLUSTERS-1:0] pend_q, pend_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [N_CLUSTERS-1:0] rel_bit;

  logic [N_CLUSTERS-1:0] rst_n_q, rst_n_d;
  logic [N_CLUSTERS-1:0] fetch_q, fetch_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic start_ok;
  assign start_ok = start_i && (cl_mask_i != '0);

  function automatic logic [N_CLUSTERS-1:0] lowest_bit(input logic [N_CLUSTERS-1:0] v);
    return v & (~v + N_CLUSTERS'(1));
  endfunction

  // State register and sequencing bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ResetState;
      mask_q  <= ResetMask;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; rel_bit flags the cluster whose reset is released on this edge.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    rel_bit = '0;
    if (stop_i) begin
      state_d = StIdle;
      pend_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StRun: begin
          if (start_ok) begin
            state_d = StHold;
            mask_d  = cl_mask_i;
            cnt_d   = '0;
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            state_d = StRelease;
            rel_bit = lowest_bit(mask_q);
            pend_d  = mask_q & ~rel_bit;
            cnt_d   = '0;
          end
        end
        StRelease: begin
          if (pend_q == '0) begin
            state_d = StRun;
          end else if (cnt_q == StagLast) begin
            rel_bit = lowest_bit(pend_q);
            pend_d  = pend_q & ~rel_bit;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    busy_d  = (state_d == StHold) || (state_d == StRelease);
    done_d  = (state_d == StRun);
    fetch_d = (state_d == StRun) ? mask_d : '0;
    rst_n_d = ((state_d == StIdle) || (state_d == StHold)) ? '0 : (rst_n_q | rel_bit);
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_n_q <= '0;
      fetch_q <= '0;
      busy_q  <= ResetBusy;
      done_q  <= 1'b0;
    end else begin
      rst_n_q <= rst_n_d;
      fetch_q <= fetch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cluster_rst_no = rst_n_q;
  assign fetch_en_o     = fetch_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

  // Status word packs flop outputs only, so it is glitch-free for the APB read path.
  always_comb begin
    status_o = '0;
    status_o[2*N_CLUSTERS+1:0] = {fetch_q, rst_n_q, done_q, busy_q};
  end

endmodule

// File: tb/tb_soc_cluster_boot_seq.sv
// Directed bench for soc_cluster_boot_seq (N_CLUSTERS=4, hold 16, stagger 8).
// Honours SOC_BOOT_SEQ_AUTOBOOT_EN when the bundle is built with it.
module tb_soc_cluster_boot_seq;

`ifdef SOC_BOOT_SEQ_AUTOBOOT_EN
  localparam logic RST_BUSY = 1'b1;
`else
  localparam logic RST_BUSY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  mask = '0;
  logic [3:0]  cl_rst_n;
  logic [3:0]  fetch_en;
  logic        busy;
  logic        done;
  logic [31:0] status;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  string tname;

  typedef struct {
    int         cyc;
    logic       start;
    logic       stop;
    logic [3:0] mask;
    logic [3:0] rst_no;
    logic [3:0] fe;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  soc_cluster_boot_seq #(
    .N_CLUSTERS     (4),
    .DATA_WIDTH     (32),
    .RST_HOLD_CYCLES(16),
    .STAGGER_CYCLES (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .stop_i        (stop),
    .cl_mask_i     (mask),
    .cluster_rst_no(cl_rst_n),
    .fetch_en_o    (fetch_en),
    .busy_o        (busy),
    .done_o        (done),
    .status_o      (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s @c%0d: got %h want %h", tname, name, cyc, act, exp);
    end
  endtask

  task automatic check_all(input logic [3:0] r, input logic [3:0] f, input logic b,
                           input logic d);
    check("rst_no", 32'(cl_rst_n), 32'(r));
    check("fetch_en", 32'(fetch_en), 32'(f));
    check("busy", 32'(busy), 32'(b));
    check("done", 32'(done), 32'(d));
    check("status", status, {22'd0, f, r, d, b});
  endtask

  // One clock: inputs are pulses, so they drop after every sampling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mask  = '0;
    #3;
    check_all(4'h0, 4'h0, RST_BUSY, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic add(input int c, input logic st, input logic sp, input logic [3:0] m,
                     input logic [3:0] r, input logic [3:0] f, input logic b, input logic d);
    vec_t v;
    v.cyc = c; v.start = st; v.stop = sp; v.mask = m;
    v.rst_no = r; v.fe = f; v.busy = b; v.done = d;
    vecs.push_back(v);
  endtask

  // Check outputs at each record's cycle, then drive that record's inputs for the cycle.
  task automatic run_vecs();
    foreach (vecs[i]) begin
      goto(vecs[i].cyc);
      check_all(vecs[i].rst_no, vecs[i].fe, vecs[i].busy, vecs[i].done);
      start = vecs[i].start;
      stop  = vecs[i].stop;
      mask  = vecs[i].mask;
    end
    vecs.delete();
  endtask

  initial begin
`ifdef SOC_BOOT_SEQ_AUTOBOOT_EN
    tname = "autoboot";
    do_reset();
    add(0,  0, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    add(15, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    add(16, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0);
    add(24, 0, 0, 4'h0, 4'h3, 4'h0, 1, 0);
    add(32, 0, 0, 4'h0, 4'h7, 4'h0, 1, 0);
    add(40, 0, 0, 4'h0, 4'hF, 4'h0, 1, 0);
    add(41, 0, 0, 4'h0, 4'hF, 4'hF, 0, 1);
    add(42, 0, 1, 4'h0, 4'hF, 4'hF, 0, 1);
    add(43, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    run_vecs();
`else
    tname = "idle_reset";
    do_reset();
    goto(100);
    check_all(4'h0, 4'h0, 1'b0, 1'b0);

    tname = "full_mask_then_restart";
    do_reset();
    add(0,  1, 0, 4'hF, 4'h0, 4'h0, 0, 0);
    add(1,  0, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    add(16, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    add(17, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0);
    add(24, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0);
    add(25, 0, 0, 4'h0, 4'h3, 4'h0, 1, 0);
    add(32, 0, 0, 4'h0, 4'h3, 4'h0, 1, 0);
    add(33, 0, 0, 4'h0, 4'h7, 4'h0, 1, 0);
    add(41, 0, 0, 4'h0, 4'hF, 4'h0, 1, 0);
    add(42, 0, 0, 4'h0, 4'hF, 4'hF, 0, 1);
    add(50, 1, 0, 4'h2, 4'hF, 4'hF, 0, 1);
    add(51, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    add(66, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    add(67, 0, 0, 4'h0, 4'h2, 4'h0, 1, 0);
    add(68, 0, 0, 4'h0, 4'h2, 4'h2, 0, 1);
    add(80, 0, 0, 4'h0, 4'h2, 4'h2, 0, 1);
    run_vecs();

    tname = "sparse_mask";
    do_reset();
    add(0,  1, 0, 4'h5, 4'h0, 4'h0, 0, 0);
    add(17, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0);
    add(20, 1, 0, 4'hF, 4'h1, 4'h0, 1, 0);
    add(24, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0);
    add(25, 0, 0, 4'h0, 4'h5, 4'h0, 1, 0);
    add(26, 0, 0, 4'h0, 4'h5, 4'h5, 0, 1);
    add(40, 0, 1, 4'h0, 4'h5, 4'h5, 0, 1);
    add(41, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    run_vecs();

    tname = "stop_mid_release";
    do_reset();
    add(0,  1, 0, 4'hF, 4'h0, 4'h0, 0, 0);
    add(29, 0, 0, 4'h0, 4'h3, 4'h0, 1, 0);
    add(30, 0, 1, 4'h0, 4'h3, 4'h0, 1, 0);
    add(31, 1, 0, 4'h3, 4'h0, 4'h0, 0, 0);
    add(32, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    add(47, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0);
    add(48, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0);
    add(56, 0, 0, 4'h0, 4'h3, 4'h0, 1, 0);
    add(57, 0, 0, 4'h0, 4'h3, 4'h3, 0, 1);
    run_vecs();

    tname = "idle_ignored_starts";
    do_reset();
    add(0,  1, 1, 4'hF, 4'h0, 4'h0, 0, 0);
    add(1,  1, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    add(2,  0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    add(25, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    run_vecs();

    tname = "async_reset_mid_seq";
    do_reset();
    add(0,  1, 0, 4'hF, 4'h0, 4'h0, 0, 0);
    add(30, 0, 0, 4'h0, 4'h3, 4'h0, 1, 0);
    run_vecs();
    #2;
    rst_n = 1'b0;
    #1;
    check_all(4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    cyc = 0;
    add(0,  0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    add(30, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    run_vecs();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
